cplx_addsub_pipe: RTL and testbench
===================================

// Module: cplx_addsub_pipe
// PURPOSE
//  Parametrised, pipelined complex adder/subtractor for the complex-arithmetic datapath.
//  Takes A=(a_re,a_im) and B=(b_re,b_im) and applies one of four ops per transaction.
//  Supports ready/valid backpressure, a wrap or saturate mode, and per-component overflow flags.
//  Drives a packed {re,im} result to the downstream multiplier/accumulator stages.
// PARAMETERS
//  W        32  component width, two's complement signed
//  SAT      0   0: wrap modulo 2^W; 1: saturate to [-2^(W-1), 2^(W-1)-1]
// PORTS
//  clock      in   1    clock, rising edge
//  reset      in   1    synchronous, active-high
//  in_valid   in   1    input transaction valid
//  in_ready   out  1    block can accept this cycle
//  op         in   2    00 A+B, 01 A-B, 10 A+conj(B), 11 A-conj(B)
//  a_re,a_im  in   W    operand A
//  b_re,b_im  in   W    operand B
//  out_valid  out  1    result valid
//  out_ready  in   1    downstream accepts
//  out        out  2W   {re, im}, re in [2W-1:W]
//  ovf        out  2    {ovf_re, ovf_im}: true result not representable in W bits
// BEHAVIOUR
//  - Transfer occurs when valid&&ready on a port in the same cycle. No other condition moves data.
//  - Two register stages (S1, S2), each with its own valid bit. Latency is 2 cycles from input
//    transfer to out_valid when out_ready=1. Full throughput is 1 transaction/cycle.
//  - S1: sign-extend operands to W+1 bits and compute exact sums:
//      re = a_re +/- b_re
//      im = a_im +/- b_im   (sign taken from the op table; conj negates b_im)
//      00: re=a+b, im=a+b   01: re=a-b, im=a-b
//      10: re=a+b, im=a-b   11: re=a-b, im=a+b
//  - S2: reduce W+1 to W bits. ovf bit = (bit W != bit W-1) of the exact sum.
//      SAT=0: truncate, so the result wraps.
//      SAT=1: positive overflow -> 0x7F..F; negative overflow -> 0x80..0.
//      The ovf flag is reported in both modes.
//  - Pipeline advance:
//      s2_adv = !s2_v || out_ready
//      s1_adv = !s1_v || s2_adv
//      in_ready = s1_adv   (combinational from out_ready; no skid buffer)
//  - A stalled stage holds its data and flags stable. out/ovf must not change while
//    out_valid && !out_ready.
//  - Simultaneous output drain and input accept with all stages full: every stage shifts,
//    no bubble, no loss.
//  - Payload is ignored when in_valid=0. Stage registers load only on advance.
//  - reset: s1_v=s2_v=0, out_valid=0, out=0, ovf=0.
//      in_ready=1 from the first cycle after reset.
//      Reset mid-transaction discards all in-flight data. No partial output is emitted.
//  - op is sampled with the operands at input transfer. A change of op while stalled
//    has no effect on in-flight data.
//  - Extreme case -2^(W-1) - (-2^(W-1)) = 0 exactly, so ovf=0.
//    Case 0 - (-2^(W-1)) overflows positive.
// STRUCTURE
//  - cplx_pkg: op codes
//      OP_ADD=2'b00, OP_SUB=2'b01, OP_ADD_CONJ=2'b10, OP_SUB_CONJ=2'b11
//      helper function for packing {re,im}
//  - Sub-module sat_reduce #(W,SAT): (W+1)-bit signed in -> W-bit out + ovf.
//      Combinational; instantiated twice (re, im).
//  - Top: S1 adders, S2 registers, valid/ready control. Estimated 150-250 lines.
// TESTING
//  1. W=32,SAT=0, op=00, A=(3,5), B=(1,2), out_ready=1
//     -> out={4,7}, ovf=00, out_valid exactly 2 cycles after accept.
//  2. op=10, A=(10,10), B=(4,6) -> {14,4}; op=11, same operands -> {6,16}.
//  3. SAT=0 vs SAT=1, op=00, a_re=0x7FFFFFFF, b_re=1, im=0
//     -> SAT=0: re=0x80000000, ovf=10; SAT=1: re=0x7FFFFFFF, ovf=10.
//  4. Stream 8 back-to-back transactions; out_ready low for cycles 3-5
//     -> in_ready drops once both stages are full.
//     -> outputs stay stable while stalled; all 8 results arrive in order, none lost or duplicated.
//  5. Assert reset while both stages are valid, then release
//     -> out_valid=0, out=0, ovf=0 next cycle; no stale result appears afterwards.
//  6. Random ops and operands, random in_valid/out_ready, 10k transactions
//     -> scoreboard matches the exact-arithmetic model including ovf and saturation.

Source files
------------

// File: rtl/cplx_pkg.sv
// Package: cplx_pkg
// Shared definitions for the complex add/subtract datapath.
//   cplx_op_e    : operation codes carried on the 2-bit op field
//   op_re_sub()  : 1 when the real component is a subtraction
//   op_im_sub()  : 1 when the imaginary component is a subtraction
package cplx_pkg;

    typedef enum logic [1:0] {
        OP_ADD      = 2'b00,  // A + B
        OP_SUB      = 2'b01,  // A - B
        OP_ADD_CONJ = 2'b10,  // A + conj(B)
        OP_SUB_CONJ = 2'b11   // A - conj(B)
    } cplx_op_e;

    // The real part only depends on add/sub; op[0] selects subtraction.
    function automatic logic op_re_sub(input logic [1:0] op);
        return op[0];
    endfunction

    // Conjugation negates b_im, which flips the im operator relative to re.
    function automatic logic op_im_sub(input logic [1:0] op);
        return op[0] ^ op[1];
    endfunction

endpackage

// File: rtl/cplx_addsub_pipe_if.sv
// Interface: cplx_addsub_pipe_if
// Bundles the input and output handshakes of the complex adder/subtractor.
//   in_valid/in_ready   : input transaction handshake
//   op, a_re/a_im, b_re/b_im : input payload
//   out_valid/out_ready : output handshake
//   out {re,im}, ovf {ovf_re,ovf_im} : output payload
// Handshake rule (both ports): a transfer happens on a rising clock edge
// where valid && ready are both high; nothing else moves data. Payload is
// don't-care while valid is low.
// Modports: master = producer of operands / consumer of results,
//           slave  = the pipeline.
interface cplx_addsub_pipe_if #(
    parameter int W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [W-1:0]     a_re;
    logic [W-1:0]     a_im;
    logic [W-1:0]     b_re;
    logic [W-1:0]     b_im;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out;
    logic [1:0]       ovf;

    modport master (
        output in_valid, op, a_re, a_im, b_re, b_im, out_ready,
        input  in_ready, out_valid, out, ovf
    );

    modport slave (
        input  in_valid, op, a_re, a_im, b_re, b_im, out_ready,
        output in_ready, out_valid, out, ovf
    );
endinterface

// File: rtl/sat_reduce.sv
// Module: sat_reduce
// Combinational reduction of an exact (W+1)-bit signed sum to W bits.
//   din  in  W+1  exact signed sum
//   dout out W    reduced value (wrapped when SAT=0, clamped when SAT=1)
//   ovf  out 1    sum not representable in W bits
module sat_reduce #(
    parameter int W   = 32,
    parameter bit SAT = 1'b0
) (
    input  logic signed [W:0] din,
    output logic [W-1:0]      dout,
    output logic              ovf
);
    localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    always_comb begin
        // The extra sign bit disagrees with the W-bit sign bit only when
        // the sum left the W-bit range; din[W] then gives the true sign.
        ovf  = din[W] ^ din[W-1];
        dout = din[W-1:0];
        if (SAT && ovf) begin
            dout = din[W] ? MIN_VAL : MAX_VAL;
        end
    end
endmodule

// File: rtl/cplx_addsub_pipe.sv
// Module: cplx_addsub_pipe
// Two-stage pipelined complex adder/subtractor with ready/valid flow control.
//   S1 holds exact (W+1)-bit component sums, S2 holds the reduced result.
// Ports:
//   clock  in  rising-edge clock
//   reset  in  synchronous, active-high; flushes all in-flight data
//   bus    slave modport of cplx_addsub_pipe_if (handshakes + payload)
// Parameters:
//   W    component width (two's complement)
//   SAT  0: wrap modulo 2^W, 1: saturate
module cplx_addsub_pipe
    import cplx_pkg::*;
#(
    parameter int W   = 32,
    parameter bit SAT = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    cplx_addsub_pipe_if.slave   bus
);

    logic                s1_v;
    logic signed [W:0]   s1_re;
    logic signed [W:0]   s1_im;
    logic                s2_v;
    logic [2*W-1:0]      s2_out;
    logic [1:0]          s2_ovf;

    logic                s1_adv;
    logic                s2_adv;
    logic                in_xfer;

    logic signed [W:0]   a_re_x;
    logic signed [W:0]   a_im_x;
    logic signed [W:0]   b_re_x;
    logic signed [W:0]   b_im_x;
    logic signed [W:0]   sum_re;
    logic signed [W:0]   sum_im;

    logic [W-1:0]        red_re;
    logic [W-1:0]        red_im;
    logic                ovf_re;
    logic                ovf_im;

    // A stage may load when it is empty or its contents move on this cycle.
    // in_ready is therefore combinational from out_ready (no skid buffer).
    assign s2_adv       = !s2_v || bus.out_ready;
    assign s1_adv       = !s1_v || s2_adv;
    assign in_xfer      = bus.in_valid && s1_adv;
    assign bus.in_ready = s1_adv;

    // One extra bit makes every add/sub exact.
    assign a_re_x = {bus.a_re[W-1], bus.a_re};
    assign a_im_x = {bus.a_im[W-1], bus.a_im};
    assign b_re_x = {bus.b_re[W-1], bus.b_re};
    assign b_im_x = {bus.b_im[W-1], bus.b_im};

    assign sum_re = op_re_sub(bus.op) ? (a_re_x - b_re_x) : (a_re_x + b_re_x);
    assign sum_im = op_im_sub(bus.op) ? (a_im_x - b_im_x) : (a_im_x + b_im_x);

    sat_reduce #(.W(W), .SAT(SAT)) u_red_re (
        .din  (s1_re),
        .dout (red_re),
        .ovf  (ovf_re)
    );

    sat_reduce #(.W(W), .SAT(SAT)) u_red_im (
        .din  (s1_im),
        .dout (red_im),
        .ovf  (ovf_im)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_v   <= 1'b0;
            s1_re  <= '0;
            s1_im  <= '0;
            s2_v   <= 1'b0;
            s2_out <= '0;
            s2_ovf <= '0;
        end else begin
            if (s1_adv) begin
                s1_v <= bus.in_valid;
                if (in_xfer) begin
                    s1_re <= sum_re;
                    s1_im <= sum_im;
                end
            end
            if (s2_adv) begin
                s2_v <= s1_v;
                // Payload only changes when a real result arrives, so the
                // last result stays visible after a bubble.
                if (s1_v) begin
                    s2_out <= {red_re, red_im};
                    s2_ovf <= {ovf_re, ovf_im};
                end
            end
        end
    end

    assign bus.out_valid = s2_v;
    assign bus.out       = s2_out;
    assign bus.ovf       = s2_ovf;

endmodule

// File: tb/tb_cplx_addsub_pipe.sv
// Testbench for cplx_addsub_pipe. Two instances (SAT=0 and SAT=1) see the
// same stimulus; each has its own expected queue fed by an exact-arithmetic
// reference model.
module tb_cplx_addsub_pipe;
    import cplx_pkg::*;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic             in_valid;
    logic [1:0]       op;
    logic [W-1:0]     a_re, a_im, b_re, b_im;
    logic             out_ready;

    cplx_addsub_pipe_if #(.W(W)) if0 ();
    cplx_addsub_pipe_if #(.W(W)) if1 ();

    assign if0.in_valid  = in_valid;
    assign if0.op        = op;
    assign if0.a_re      = a_re;
    assign if0.a_im      = a_im;
    assign if0.b_re      = b_re;
    assign if0.b_im      = b_im;
    assign if0.out_ready = out_ready;
    assign if1.in_valid  = in_valid;
    assign if1.op        = op;
    assign if1.a_re      = a_re;
    assign if1.a_im      = a_im;
    assign if1.b_re      = b_re;
    assign if1.b_im      = b_im;
    assign if1.out_ready = out_ready;

    cplx_addsub_pipe #(.W(W), .SAT(1'b0)) u_dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (if0.slave)
    );

    cplx_addsub_pipe #(.W(W), .SAT(1'b1)) u_dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (if1.slave)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;
    int n_out0   = 0;
    int n_out1   = 0;

    logic [2*W+1:0] exp_q0[$];
    logic [2*W+1:0] exp_q1[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s", name);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Exact integer arithmetic, then range test and wrap/clamp.
    function automatic logic [W:0] ref_reduce(input longint t, input bit sat);
        longint   mx;
        longint   mn;
        logic     o;
        logic [W-1:0] v;
        mx = (longint'(1) <<< (W-1)) - 1;
        mn = -(longint'(1) <<< (W-1));
        o  = (t > mx) || (t < mn);
        v  = t[W-1:0];
        if (sat && t > mx) v = mx[W-1:0];
        if (sat && t < mn) v = mn[W-1:0];
        return {v, o};
    endfunction

    function automatic logic [2*W+1:0] ref_model(input logic [1:0] o,
                                                 input logic [W-1:0] ar, input logic [W-1:0] ai,
                                                 input logic [W-1:0] br, input logic [W-1:0] bi,
                                                 input bit sat);
        longint   re_t, im_t;
        bit       re_sub, im_sub;
        logic [W:0] rr, ri;
        re_sub = (o == OP_SUB) || (o == OP_SUB_CONJ);
        im_sub = (o == OP_SUB) || (o == OP_ADD_CONJ);
        re_t = re_sub ? longint'($signed(ar)) - longint'($signed(br))
                      : longint'($signed(ar)) + longint'($signed(br));
        im_t = im_sub ? longint'($signed(ai)) - longint'($signed(bi))
                      : longint'($signed(ai)) + longint'($signed(bi));
        rr = ref_reduce(re_t, sat);
        ri = ref_reduce(im_t, sat);
        return {rr[W:1], ri[W:1], rr[0], ri[0]};
    endfunction

    // ---------------- scoreboard ----------------
    // Whenever out_valid is high the presented result must equal the oldest
    // expected one, so any change while stalled is also caught.
    always @(negedge clock) begin
        if (reset) begin
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            if (if0.out_valid) begin
                if (exp_q0.size() == 0) fail_now("sat0 unexpected output");
                else begin
                    check("sat0 out", if0.out, exp_q0[0][2*W+1:2]);
                    check("sat0 ovf", if0.ovf, exp_q0[0][1:0]);
                    if (out_ready) begin
                        void'(exp_q0.pop_front());
                        n_out0++;
                    end
                end
            end
            if (if1.out_valid) begin
                if (exp_q1.size() == 0) fail_now("sat1 unexpected output");
                else begin
                    check("sat1 out", if1.out, exp_q1[0][2*W+1:2]);
                    check("sat1 ovf", if1.ovf, exp_q1[0][1:0]);
                    if (out_ready) begin
                        void'(exp_q1.pop_front());
                        n_out1++;
                    end
                end
            end
            if (in_valid && if0.in_ready) exp_q0.push_back(ref_model(op, a_re, a_im, b_re, b_im, 1'b0));
            if (in_valid && if1.in_ready) exp_q1.push_back(ref_model(op, a_re, a_im, b_re, b_im, 1'b1));
        end
    end

    // ---------------- driver helpers ----------------
    task automatic drive(input logic [1:0] o, input logic [W-1:0] ar, input logic [W-1:0] ai,
                         input logic [W-1:0] br, input logic [W-1:0] bi);
        in_valid = 1'b1;
        op = o; a_re = ar; a_im = ai; b_re = br; b_im = bi;
    endtask

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = {1'b0, {(W-1){1'b1}}};
            2: v = {1'b1, {(W-1){1'b0}}};
            3: v = '1;
            4: v = 1;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    task automatic drive_random();
        drive(2'($urandom_range(0, 3)), rand_operand(), rand_operand(), rand_operand(), rand_operand());
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [1:0]     op;
        logic [W-1:0]   ar, ai, br, bi;
        logic [2*W-1:0] out0;
        logic [1:0]     ovf0;
        logic [2*W-1:0] out1;
        logic [1:0]     ovf1;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int  idx, cyc, acc_cnt, v_cnt, base0, base1;
        bit  acc, saw_drop, pending;
        logic [1:0]   t_op[8];
        logic [W-1:0] t_v[8][4];

        vecs[0] = '{OP_ADD,      32'd3, 32'd5, 32'd1, 32'd2,
                    {32'd4, 32'd7}, 2'b00, {32'd4, 32'd7}, 2'b00};
        vecs[1] = '{OP_ADD_CONJ, 32'd10, 32'd10, 32'd4, 32'd6,
                    {32'd14, 32'd4}, 2'b00, {32'd14, 32'd4}, 2'b00};
        vecs[2] = '{OP_SUB_CONJ, 32'd10, 32'd10, 32'd4, 32'd6,
                    {32'd6, 32'd16}, 2'b00, {32'd6, 32'd16}, 2'b00};
        vecs[3] = '{OP_ADD,      32'h7FFFFFFF, 32'd0, 32'd1, 32'd0,
                    {32'h80000000, 32'd0}, 2'b10, {32'h7FFFFFFF, 32'd0}, 2'b10};
        vecs[4] = '{OP_SUB,      32'h80000000, 32'd0, 32'h80000000, 32'h80000000,
                    {32'd0, 32'h80000000}, 2'b01, {32'd0, 32'h7FFFFFFF}, 2'b01};
        vecs[5] = '{OP_ADD,      32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,
                    {32'h7FFFFFFF, 32'd0}, 2'b10, {32'h80000000, 32'd0}, 2'b10};
        vecs[6] = '{OP_ADD_CONJ, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFD, 32'd7,
                    {32'hFFFFFFFD, 32'hFFFFFFF4}, 2'b00, {32'hFFFFFFFD, 32'hFFFFFFF4}, 2'b00};

        // Reset and reset values.
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a_re = '0; a_im = '0; b_re = '0; b_im = '0;
        repeat (3) step();
        check("reset out_valid", {if1.out_valid, if0.out_valid}, 2'b00);
        check("reset out0", if0.out, '0);
        check("reset out1", if1.out, '0);
        check("reset ovf", {if1.ovf, if0.ovf}, 4'b0);
        reset = 1'b0;
        step();
        check("in_ready after reset", {if1.in_ready, if0.in_ready}, 2'b11);

        // Directed vectors with latency check.
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].op, vecs[i].ar, vecs[i].ai, vecs[i].br, vecs[i].bi);
            step();
            in_valid = 1'b0;
            check("vec early out_valid", {if1.out_valid, if0.out_valid}, 2'b00);
            step();
            check("vec latency out_valid", {if1.out_valid, if0.out_valid}, 2'b11);
            check("vec out sat0", if0.out, vecs[i].out0);
            check("vec ovf sat0", if0.ovf, vecs[i].ovf0);
            check("vec out sat1", if1.out, vecs[i].out1);
            check("vec ovf sat1", if1.ovf, vecs[i].ovf1);
            step();
        end

        // Eight back-to-back transactions with out_ready low in cycles 3-5.
        for (int i = 0; i < 8; i++) begin
            t_op[i] = 2'(i % 4);
            for (int k = 0; k < 4; k++) t_v[i][k] = rand_operand();
        end
        base0 = n_out0; base1 = n_out1;
        idx = 0; cyc = 0; saw_drop = 1'b0;
        while ((idx < 8 || exp_q0.size() != 0 || exp_q1.size() != 0) && cyc < 100) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            if (idx < 8) drive(t_op[idx], t_v[idx][0], t_v[idx][1], t_v[idx][2], t_v[idx][3]);
            else in_valid = 1'b0;
            @(negedge clock);
            if (!if0.in_ready) saw_drop = 1'b1;
            acc = in_valid && if0.in_ready;
            step();
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        if (cyc >= 100) fail_now("stream timeout");
        check("stream in_ready dropped", saw_drop, 1'b1);
        check("stream count sat0", n_out0 - base0, 8);
        check("stream count sat1", n_out1 - base1, 8);

        // Reset with both stages full.
        out_ready = 1'b0;
        drive(OP_ADD, 32'd100, 32'd200, 32'd1, 32'd2);
        step();
        drive(OP_SUB, 32'd300, 32'd400, 32'd3, 32'd4);
        step();
        in_valid = 1'b0;
        step();
        check("prefill out_valid", {if1.out_valid, if0.out_valid}, 2'b11);
        check("prefill in_ready", {if1.in_ready, if0.in_ready}, 2'b00);
        reset = 1'b1;
        step();
        check("midreset out_valid", {if1.out_valid, if0.out_valid}, 2'b00);
        check("midreset out0", if0.out, '0);
        check("midreset out1", if1.out, '0);
        check("midreset ovf", {if1.ovf, if0.ovf}, 4'b0);
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        check("postreset in_ready", {if1.in_ready, if0.in_ready}, 2'b11);
        v_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (if0.out_valid || if1.out_valid) v_cnt++;
            step();
        end
        check("postreset no stale output", v_cnt, 0);

        // Random traffic against the model.
        base0 = n_out0; base1 = n_out1;
        acc_cnt = 0; cyc = 0; pending = 1'b0;
        while (acc_cnt < 10000 && cyc < 60000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pending) begin
                if ($urandom_range(0, 3) != 0) drive_random();
                else begin
                    // Garbage payload with valid low must be ignored.
                    drive_random();
                    in_valid = 1'b0;
                end
            end
            @(negedge clock);
            acc = in_valid && if0.in_ready;
            pending = in_valid && !acc;
            step();
            if (acc) acc_cnt++;
            cyc++;
        end
        if (acc_cnt < 10000) fail_now("random traffic timeout");
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && cyc < 20) begin
            step();
            cyc++;
        end
        check("random drain sat0", exp_q0.size(), 0);
        check("random drain sat1", exp_q1.size(), 0);
        check("random count sat0", n_out0 - base0, acc_cnt);
        check("random count sat1", n_out1 - base1, acc_cnt);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
